// File: rtl/prefetcher_block_queue_if.sv
// prefetcher_block_queue_if: opcode/request bus from the prefetcher control FSM plus
// DDR/NVDLA beat data and status flags returned by the block queue.
interface prefetcher_block_queue_if #(
  parameter int ADDR_BITS = 64,
  parameter int LOG_QUEUE_SIZE = 6,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH = 512
);
  logic                       pr_flush;
  logic [2:0]                 pr_opCode;
  logic [ADDR_BITS-1:0]       pr_m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] pr_m_ar_len;
  logic [DATA_WIDTH-1:0]      m_r_data;
  logic [DATA_WIDTH-1:0]      s_r_data;
  logic                       s_r_last;
  logic                       pr_addrHit;
  logic                       pr_hasOutstanding;
  logic [LOG_QUEUE_SIZE:0]    pr_reqCnt;
  logic                       pr_almostFull;
  logic                       pr_r_valid;
  modport master (
    output pr_flush, pr_opCode, pr_m_ar_addr, pr_m_ar_len, m_r_data,
    input  s_r_data, s_r_last, pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull, pr_r_valid
  );
  modport slave (
    input  pr_flush, pr_opCode, pr_m_ar_addr, pr_m_ar_len, m_r_data,
    output s_r_data, s_r_last, pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull, pr_r_valid
  );
endinterface

// File: rtl/prefetcher_block_queue.sv
// prefetcher_block_queue: circular beat-granular queue between DDR R data and NVDLA R data.
// Defining PR_QUEUE_STATS_EN adds saturating hit/miss/drop counters.
module prefetcher_block_queue #(
  parameter int ADDR_BITS = 64,
  parameter int OFFSET_BITS = 6,
  parameter int LOG_QUEUE_SIZE = 6,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH = 512
) (
  input logic clk,
  input logic resetN,
  prefetcher_block_queue_if.slave pr
`ifdef PR_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_hitCnt,
  output logic [31:0] stat_missCnt,
  output logic [31:0] stat_dropCnt
`endif
);
  localparam int L = LOG_QUEUE_SIZE;
  localparam int Q = 1 << L;
  localparam int PW = L + 1;
  localparam int CW = (BURST_LEN_WIDTH > L ? BURST_LEN_WIDTH : L) + 2;
  logic [PW-1:0] head, prom_ptr, wr_ptr, tail, used, req_cnt;
  logic [Q-1:0][ADDR_BITS-1:0] slot_addr;
  logic [Q-1:0][DATA_WIDTH-1:0] slot_data;
  logic [Q-1:0] dv, promised, drop, last, alloc_m, prom_m, drop_m, last_m;
  logic [Q-1:0][L-1:0] off_t, off_p;
  logic [L-1:0] h_idx, w_idx;
  logic [CW-1:0] free_w, n_w, req_w;
  logic mgr, wr, fits, hit, alloc, rv, pop, discard;
  always_comb begin
    used = tail - head;
    req_cnt = tail - prom_ptr;
    h_idx = head[L-1:0];
    w_idx = wr_ptr[L-1:0];
    free_w = CW'(Q) - CW'(used);
    n_w = CW'(pr.pr_m_ar_len) + CW'(1);
    req_w = CW'(req_cnt);
    fits = free_w >= n_w;
    hit = (prom_ptr != tail) && (slot_addr[prom_ptr[L-1:0]] == pr.pr_m_ar_addr) && (req_w >= n_w);
    mgr = pr.pr_opCode == 3'd2;
    wr = pr.pr_opCode == 3'd3 && wr_ptr != tail;
    alloc = (pr.pr_opCode == 3'd1 || (mgr && !hit)) && fits;
    rv = head != wr_ptr && dv[h_idx] && promised[h_idx] && !drop[h_idx];
    pop = pr.pr_opCode == 3'd4 && rv;
    discard = head != wr_ptr && drop[h_idx] && dv[h_idx];
    // Per-slot distance from tail / promPtr turns range updates into parallel compares
    for (int i = 0; i < Q; i++) begin
      off_t[i] = L'(i) - tail[L-1:0];
      off_p[i] = L'(i) - prom_ptr[L-1:0];
      alloc_m[i] = CW'(off_t[i]) < n_w;
      last_m[i] = CW'(off_t[i]) == n_w - CW'(1);
      prom_m[i] = CW'(off_p[i]) < n_w;
      drop_m[i] = CW'(off_p[i]) < req_w;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      {head, prom_ptr, wr_ptr, tail} <= '0;
      {dv, promised, drop, last} <= '0;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (pr.pr_flush) begin
      {head, prom_ptr, wr_ptr, tail} <= '0;
      {dv, promised, drop, last} <= '0;
    end else begin
      for (int i = 0; i < Q; i++) begin
        if (alloc && alloc_m[i]) begin
          slot_addr[i] <= pr.pr_m_ar_addr + (ADDR_BITS'(off_t[i]) << OFFSET_BITS);
          promised[i] <= mgr;
          last[i] <= last_m[i];
          dv[i] <= 1'b0;
          drop[i] <= 1'b0;
        end
        if (mgr && hit && prom_m[i]) promised[i] <= 1'b1;
        if (mgr && !hit && drop_m[i]) drop[i] <= 1'b1;
      end
      if (wr) begin
        slot_data[w_idx] <= pr.m_r_data;
        dv[w_idx] <= 1'b1;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop || discard) begin
        head <= head + PW'(1);
        {dv[h_idx], promised[h_idx], drop[h_idx], last[h_idx]} <= '0;
      end
      if (alloc) tail <= tail + PW'(n_w);
      // A miss abandons every unpromised slot, so promPtr always lands on the new tail
      if (mgr) prom_ptr <= hit ? prom_ptr + PW'(n_w) : alloc ? tail + PW'(n_w) : tail;
    end
`ifdef PR_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      {stat_hitCnt, stat_missCnt, stat_dropCnt} <= '0;
    end else if (!pr.pr_flush) begin
      if (mgr && hit && ~&stat_hitCnt) stat_hitCnt <= stat_hitCnt + 32'd1;
      if (mgr && !hit && ~&stat_missCnt) stat_missCnt <= stat_missCnt + 32'd1;
      if (discard && ~&stat_dropCnt) stat_dropCnt <= stat_dropCnt + 32'd1;
    end
`endif
  assign pr.s_r_data = slot_data[h_idx];
  assign pr.s_r_last = last[h_idx];
  assign pr.pr_addrHit = hit;
  assign pr.pr_hasOutstanding = wr_ptr != tail;
  assign pr.pr_reqCnt = req_cnt;
  assign pr.pr_almostFull = free_w < CW'(Q / 2);
  assign pr.pr_r_valid = rv;
endmodule

// File: tb/tb_prefetcher_block_queue.sv
// tb_prefetcher_block_queue: directed and randomized checks of prefetcher_block_queue
// against an ordered-entry queue model.
module tb_prefetcher_block_queue;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;
  prefetcher_block_queue_if bus ();
  prefetcher_block_queue dut (.clk(clk), .resetN(resetN), .pr(bus));

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
    bit dv, pr, dr, last;
  } ent_t;
  ent_t q[$];
  int wi, pi, n_cmp, n_bad;
  bit chk_on;
  logic [511:0] d0, d1;
  logic [63:0] a;
  logic [7:0] len;
  logic [2:0] op;
  int r;

  function automatic void m_reset();
    q.delete();
    wi = 0;
    pi = 0;
  endfunction
  function automatic bit m_rv();
    return wi > 0 && q[0].dv && q[0].pr && !q[0].dr;
  endfunction
  function automatic bit m_hit(input logic [63:0] ad, input logic [7:0] ln);
    return pi < q.size() && q[pi].addr == ad && q.size() - pi >= int'(ln) + 1;
  endfunction
  function automatic void m_step(input logic [2:0] o, input logic [63:0] ad, input logic [7:0] ln,
                                 input logic [511:0] d, input logic fl);
    int n;
    bit fits, pop, disc, h;
    ent_t e;
    if (fl) begin
      m_reset();
      return;
    end
    n = int'(ln) + 1;
    fits = 64 - q.size() >= n;
    pop = o == 3'd4 && m_rv();
    disc = wi > 0 && q[0].dr && q[0].dv;
    h = m_hit(ad, ln);
    if (o == 3'd3 && wi < q.size()) begin
      e = q[wi]; e.data = d; e.dv = 1'b1; q[wi] = e; wi++;
    end
    if (o == 3'd2 && h) begin
      for (int i = pi; i < pi + n; i++) begin e = q[i]; e.pr = 1'b1; q[i] = e; end
      pi += n;
    end
    if (o == 3'd2 && !h)
      for (int i = pi; i < q.size(); i++) begin e = q[i]; e.dr = 1'b1; q[i] = e; end
    if ((o == 3'd1 || (o == 3'd2 && !h)) && fits)
      for (int i = 0; i < n; i++) begin
        e.addr = ad + 64'(i) * 64;
        e.data = '0;
        e.dv = 1'b0;
        e.pr = o == 3'd2;
        e.dr = 1'b0;
        e.last = i == n - 1;
        q.push_back(e);
      end
    if (o == 3'd2 && !h) pi = q.size();
    if (pop || disc) begin
      void'(q.pop_front());
      wi--;
      pi--;
    end
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] o, input logic [63:0] ad, input logic [7:0] ln,
                       input logic [511:0] d, input logic fl);
    bus.pr_opCode = o;
    bus.pr_m_ar_addr = ad;
    bus.pr_m_ar_len = ln;
    bus.m_r_data = d;
    bus.pr_flush = fl;
  endtask
  task automatic tick();
    @(posedge clk);
    #1 drive(3'd0, '0, '0, '0, 1'b0);
  endtask
  task automatic cyc(input logic [2:0] o, input logic [63:0] ad, input logic [7:0] ln,
                     input logic [511:0] d, input logic fl);
    drive(o, ad, ln, d, fl);
    tick();
  endtask
  function automatic logic [511:0] rnd_data();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge resetN) m_reset();
  always @(posedge clk)
    if (resetN === 1'b1)
      m_step(bus.pr_opCode, bus.pr_m_ar_addr, bus.pr_m_ar_len, bus.m_r_data, bus.pr_flush);

  always @(negedge clk)
    if (resetN === 1'b1 && chk_on) begin
      check("cmp reqCnt", 512'(bus.pr_reqCnt), 512'(q.size() - pi));
      check("cmp hasOutstanding", 512'(bus.pr_hasOutstanding), 512'(wi != q.size()));
      check("cmp almostFull", 512'(bus.pr_almostFull), 512'(64 - q.size() < 32));
      check("cmp r_valid", 512'(bus.pr_r_valid), 512'(m_rv()));
      check("cmp addrHit", 512'(bus.pr_addrHit), 512'(m_hit(bus.pr_m_ar_addr, bus.pr_m_ar_len)));
      if (m_rv()) begin
        check("cmp s_r_data", bus.s_r_data, q[0].data);
        check("cmp s_r_last", 512'(bus.s_r_last), 512'(q[0].last));
      end
    end

  initial begin
    chk_on = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    m_reset();
    drive(3'd0, '0, '0, '0, 1'b0);
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    chk_on = 1'b1;
    check("rst reqCnt", 512'(bus.pr_reqCnt), 0);
    check("rst hasOutstanding", 512'(bus.pr_hasOutstanding), 0);
    check("rst almostFull", 512'(bus.pr_almostFull), 0);
    check("rst r_valid", 512'(bus.pr_r_valid), 0);
    check("rst addrHit", 512'(bus.pr_addrHit), 0);
    check("rst s_r_last", 512'(bus.s_r_last), 0);
    check("rst s_r_data", bus.s_r_data, 0);

    d0 = rnd_data();
    d1 = rnd_data();
    cyc(3'd1, 64'h1000, 8'd1, '0, 1'b0);
    check("t1 reqCnt", 512'(bus.pr_reqCnt), 2);
    check("t1 model reqCnt", 512'(q.size() - pi), 2);
    check("t1 outstanding", 512'(bus.pr_hasOutstanding), 1);
    cyc(3'd3, '0, '0, d0, 1'b0);
    cyc(3'd3, '0, '0, d1, 1'b0);
    check("t1 outstanding after beats", 512'(bus.pr_hasOutstanding), 0);
    drive(3'd2, 64'h1000, 8'd1, '0, 1'b0);
    #1 check("t1 addrHit", 512'(bus.pr_addrHit), 1);
    check("t1 model hit", 512'(m_hit(64'h1000, 8'd1)), 1);
    tick();
    check("t1 reqCnt after hit", 512'(bus.pr_reqCnt), 0);
    check("t1 r_valid", 512'(bus.pr_r_valid), 1);
    check("t1 beat0 data", bus.s_r_data, d0);
    cyc(3'd4, '0, '0, '0, 1'b0);
    check("t1 beat1 data", bus.s_r_data, d1);
    check("t1 beat1 last", 512'(bus.s_r_last), 1);
    cyc(3'd4, '0, '0, '0, 1'b0);
    check("t1 r_valid drained", 512'(bus.pr_r_valid), 0);

    cyc(3'd1, 64'h2000, 8'd0, '0, 1'b0);
    cyc(3'd3, '0, '0, d0, 1'b0);
    drive(3'd2, 64'h3000, 8'd0, '0, 1'b0);
    #1 check("t2 addrHit", 512'(bus.pr_addrHit), 0);
    tick();
    check("t2 r_valid on dropped head", 512'(bus.pr_r_valid), 0);
    check("t2 model head dropped", 512'(q[0].dr), 1);
    cyc(3'd3, '0, '0, d1, 1'b0);
    check("t2 r_valid demand", 512'(bus.pr_r_valid), 1);
    check("t2 demand data", bus.s_r_data, d1);
    cyc(3'd4, '0, '0, '0, 1'b0);

    cyc(3'd0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 32; i++) cyc(3'd1, 64'h10000 + 64'(i) * 64, 8'd0, '0, 1'b0);
    check("t3 almostFull used32", 512'(bus.pr_almostFull), 0);
    cyc(3'd1, 64'h20000, 8'd0, '0, 1'b0);
    check("t3 almostFull used33", 512'(bus.pr_almostFull), 1);
    for (int i = 0; i < 31; i++) cyc(3'd1, 64'h30000 + 64'(i) * 64, 8'd0, '0, 1'b0);
    check("t3 reqCnt full", 512'(bus.pr_reqCnt), 64);
    cyc(3'd1, 64'h40000, 8'd0, '0, 1'b0);
    check("t3 reqCnt after ignored op1", 512'(bus.pr_reqCnt), 64);
    check("t3 model size full", 512'(q.size()), 64);
    cyc(3'd0, '0, '0, '0, 1'b1);

    for (int k = 0; k < 100; k++) begin
      a = 64'h80000 + 64'(k) * 64;
      d0 = rnd_data();
      cyc(3'd1, a, 8'd0, '0, 1'b0);
      cyc(3'd3, '0, '0, d0, 1'b0);
      cyc(3'd2, a, 8'd0, '0, 1'b0);
      check("t4 wrap data", bus.s_r_data, d0);
      cyc(3'd4, '0, '0, '0, 1'b0);
      check("t4 wrap r_valid after pop", 512'(bus.pr_r_valid), 0);
    end

    d0 = rnd_data();
    d1 = rnd_data();
    cyc(3'd1, 64'h5000, 8'd2, '0, 1'b0);
    check("t5 outstanding before flush", 512'(bus.pr_hasOutstanding), 1);
    cyc(3'd3, '0, '0, d0, 1'b1);
    check("t5 reqCnt", 512'(bus.pr_reqCnt), 0);
    check("t5 outstanding", 512'(bus.pr_hasOutstanding), 0);
    check("t5 r_valid", 512'(bus.pr_r_valid), 0);
    cyc(3'd1, 64'h5000, 8'd0, '0, 1'b0);
    check("t5 beat not written", 512'(bus.pr_hasOutstanding), 1);
    cyc(3'd3, '0, '0, d1, 1'b0);
    cyc(3'd2, 64'h5000, 8'd0, '0, 1'b0);
    check("t5 data after flush", bus.s_r_data, d1);
    cyc(3'd4, '0, '0, '0, 1'b0);

    cyc(3'd1, 64'h6000, 8'd3, '0, 1'b0);
    cyc(3'd3, '0, '0, d0, 1'b0);
    cyc(3'd2, 64'h6000, 8'd3, '0, 1'b0);
    check("t6 r_valid before reset", 512'(bus.pr_r_valid), 1);
    cyc(3'd3, '0, '0, d1, 1'b0);
    #2 resetN = 1'b0;
    #1 check("t6 reqCnt", 512'(bus.pr_reqCnt), 0);
    check("t6 outstanding", 512'(bus.pr_hasOutstanding), 0);
    check("t6 almostFull", 512'(bus.pr_almostFull), 0);
    check("t6 r_valid", 512'(bus.pr_r_valid), 0);
    check("t6 addrHit", 512'(bus.pr_addrHit), 0);
    check("t6 s_r_last", 512'(bus.s_r_last), 0);
    check("t6 s_r_data", bus.s_r_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(199));
      len = ($urandom_range(15) == 0) ? 8'($urandom_range(40)) : 8'($urandom_range(3));
      a = {44'h0, 4'($urandom_range(15)), 16'h0};
      op = r < 50 ? 3'd1 : r < 90 ? 3'd2 : r < 140 ? 3'd3 : r < 190 ? 3'd4 : 3'($urandom_range(7));
      if (op == 3'd2 && pi < q.size() && $urandom_range(2) != 0) begin
        a = q[pi].addr;
        len = 8'($urandom_range(q.size() - pi - 1));
      end
      cyc(op, a, len, rnd_data(), r == 199);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
